// File: rtl/croc_rst_seq.sv
// croc_rst_seq: reset and boot sequencer for multi-domain croc SoCs.
//
// The asynchronous pad reset is synchronised and then released to the reset
// domains one after another, with domain 0 (core) first. The pad fetch enable
// is synchronised and only passed to the core once every domain is running.
// Each domain can also be given a timed soft-reset pulse. A registered copy of
// core busy is provided as status.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   testmode_i    1: every rst_no bit follows rst_ni combinationally (DFT bypass)
//   fetch_en_i    asynchronous boot enable from the pad
//   sw_rst_req_i  per-domain soft-reset request
//   core_busy_i   core busy flag from domain 0
//   rst_no        per-domain active-low reset
//   fetch_en_o    synchronised, gated fetch enable to the core
//   seq_done_o    high while the sequencer is in RUN
//   status_o      core_busy_i delayed one cycle, forced low while rst_no[0] is low
//
// Request semantics: sw_rst_req_i is a single-cycle pulse sampled on the rising
// clock edge. There is no ready/acknowledge path. A request is acted on only
// while the sequencer is in RUN. At any other time it is dropped and is not
// queued.
//
// The FSM state is held in state_q (type state_e) so checkers can bind to it.
module croc_rst_seq #(
  parameter int NumDomains  = 2,
  parameter int SyncStages  = 2,
  parameter int ReleaseGap  = 4,
  parameter int SwRstCycles = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  testmode_i,
  input  logic                  fetch_en_i,
  input  logic [NumDomains-1:0] sw_rst_req_i,
  input  logic                  core_busy_i,
  output logic [NumDomains-1:0] rst_no,
  output logic                  fetch_en_o,
  output logic                  seq_done_o,
  output logic                  status_o
);

  localparam int CntMax = (ReleaseGap > SwRstCycles) ? ReleaseGap : SwRstCycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam int IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  localparam logic [CntW-1:0] GapLast = CntW'(ReleaseGap - 1);
  localparam logic [CntW-1:0] GapSat  = CntW'(CntMax);
  localparam logic [CntW-1:0] SwLoad  = CntW'(SwRstCycles);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumDomains - 1);

  if (NumDomains < 1) begin : g_bad_num_domains
    $error("croc_rst_seq: NumDomains must be >= 1");
  end
  if (SyncStages < 2) begin : g_bad_sync_stages
    $error("croc_rst_seq: SyncStages must be >= 2");
  end
  if (ReleaseGap < 1) begin : g_bad_release_gap
    $error("croc_rst_seq: ReleaseGap must be >= 1");
  end
  if (SwRstCycles < 1) begin : g_bad_sw_rst_cycles
    $error("croc_rst_seq: SwRstCycles must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_SYNC       = 3'd0,
    ST_RELEASE    = 3'd1,
    ST_WAIT_FETCH = 3'd2,
    ST_RUN        = 3'd3,
    ST_CORE_RST   = 3'd4  // domain 0 in soft reset, waiting for it to come back
  } state_e;

  // Reset synchroniser: assertion is asynchronous, deassertion is clocked.
  logic [SyncStages-1:0] rst_sync_q;
  logic                  int_rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SyncStages-2:0], 1'b1};
    end
  end

  assign int_rst_n = rst_sync_q[SyncStages-1];

  // fetch_en synchroniser. fen_s is the last stage. fen_s_nxt is the value
  // fen_s takes on the next edge. The FSM uses fen_s_nxt so that it enters RUN
  // on the same edge that fen_s rises.
  logic [SyncStages-1:0] fen_sync_q;
  logic                  fen_s;
  logic                  fen_s_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fen_sync_q <= '0;
    end else begin
      fen_sync_q <= {fen_sync_q[SyncStages-2:0], fetch_en_i};
    end
  end

  assign fen_s     = fen_sync_q[SyncStages-1];
  assign fen_s_nxt = fen_sync_q[SyncStages-2];

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d, idx_nxt;
  logic [CntW-1:0]       gap_q, gap_d;
  logic [NumDomains-1:0] rel_q, rel_d;
  logic [NumDomains-1:0] rst_q, rst_d;
  logic [CntW-1:0]       sw_cnt_q [NumDomains];
  logic [CntW-1:0]       sw_cnt_d [NumDomains];
  logic                  status_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_SYNC;
      idx_q    <= '0;
      gap_q    <= '0;
      rel_q    <= '0;
      rst_q    <= '0;
      status_q <= 1'b0;
      for (int k = 0; k < NumDomains; k++) begin
        sw_cnt_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      rel_q    <= rel_d;
      rst_q    <= rst_d;
      status_q <= core_busy_i;
      for (int k = 0; k < NumDomains; k++) begin
        sw_cnt_q[k] <= sw_cnt_d[k];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    rel_d   = rel_q;
    idx_nxt = idx_q + IdxW'(1);

    // Soft-reset down-counters keep counting in every state. They are loaded
    // only from RUN. A new request reloads a running counter, which stretches
    // the pulse.
    for (int k = 0; k < NumDomains; k++) begin
      sw_cnt_d[k] = (sw_cnt_q[k] == '0) ? '0 : sw_cnt_q[k] - CntW'(1);
      if (state_q == ST_RUN && sw_rst_req_i[k]) begin
        sw_cnt_d[k] = SwLoad;
      end
    end

    case (state_q)
      ST_SYNC: begin
        if (int_rst_n) begin
          rel_d[0] = 1'b1;
          idx_d    = '0;
          gap_d    = '0;
          state_d  = (NumDomains == 1) ? ST_WAIT_FETCH : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (gap_q == GapLast) begin
          rel_d[idx_nxt] = 1'b1;
          idx_d          = idx_nxt;
          gap_d          = '0;
          if (idx_nxt == IdxLast) begin
            state_d = ST_WAIT_FETCH;
          end
        end else if (gap_q != GapSat) begin
          gap_d = gap_q + CntW'(1);
        end
      end
      ST_WAIT_FETCH: begin
        if (fen_s_nxt) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sw_rst_req_i[0]) begin
          state_d = ST_CORE_RST;
        end
      end
      ST_CORE_RST: begin
        // Leave on the edge that releases domain 0 again. RUN then follows on
        // the next edge if fen_s is still high.
        if (sw_cnt_d[0] == '0) begin
          state_d = ST_WAIT_FETCH;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    for (int k = 0; k < NumDomains; k++) begin
      rst_d[k] = rel_d[k] && (sw_cnt_d[k] == '0);
    end
  end

  // Output logic
  always_comb begin
    rst_no = rst_q;
    if (testmode_i) begin
      rst_no = {NumDomains{rst_ni}};
    end
    seq_done_o = (state_q == ST_RUN);
    fetch_en_o = (state_q == ST_RUN) && fen_s;
    status_o   = status_q && rst_no[0];
  end

endmodule

// File: tb/tb_croc_rst_seq.sv
module tb_croc_rst_seq;

  localparam int SS   = 2;
  localparam int SW   = 8;
  localparam int NA   = 2;
  localparam int GA   = 4;
  localparam int NB   = 4;
  localparam int GB   = 1;
  localparam int MAXC = 4096;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni;
  logic          testmode;
  logic          core_busy;
  logic          fe_a, fe_b;
  logic [NA-1:0] req_a;
  logic [NB-1:0] req_b;
  logic [NA-1:0] rst_a;
  logic [NB-1:0] rst_b;
  logic          fen_a, fen_b, done_a, done_b, stat_a, stat_b;

  croc_rst_seq #(
    .NumDomains(NA), .SyncStages(SS), .ReleaseGap(GA), .SwRstCycles(SW)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .testmode_i(testmode), .fetch_en_i(fe_a),
    .sw_rst_req_i(req_a), .core_busy_i(core_busy), .rst_no(rst_a),
    .fetch_en_o(fen_a), .seq_done_o(done_a), .status_o(stat_a)
  );

  croc_rst_seq #(
    .NumDomains(NB), .SyncStages(SS), .ReleaseGap(GB), .SwRstCycles(SW)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .testmode_i(testmode), .fetch_en_i(fe_b),
    .sw_rst_req_i(req_b), .core_busy_i(core_busy), .rst_no(rst_b),
    .fetch_en_o(fen_b), .seq_done_o(done_b), .status_o(stat_b)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model, kept in event-time form. Domain k of instance d is out
  // of reset once SS+1+k*gap edges have passed since the reset was released,
  // and it is not inside a soft-reset window [req, req+SW). fen_s is fetch_en
  // delayed by SS-1 edges. The sequence runs once boot is complete, domain 0
  // was already up on the previous edge, and fen_s is high.
  int m_rst_cyc [2];
  bit m_run     [2];
  int m_swend   [2][4];
  bit m_busy    [2];
  bit fe_log    [2][MAXC];

  function automatic int n_of(input int d);
    return (d == 0) ? NA : NB;
  endfunction

  function automatic int rel_at(input int d, input int k);
    return SS + 1 + k * ((d == 0) ? GA : GB);
  endfunction

  function automatic bit m_fen_s(input int d);
    int e;
    e = cyc - (SS - 1);
    if (e > m_rst_cyc[d] && e < MAXC) return fe_log[d][e];
    return 1'b0;
  endfunction

  function automatic bit exp_rst(input int d, input int k);
    if (testmode) return rst_ni;
    if (!rst_ni) return 1'b0;
    return ((cyc - m_rst_cyc[d]) >= rel_at(d, k)) && !(cyc < m_swend[d][k]);
  endfunction

  task automatic m_reset(input int d);
    m_rst_cyc[d] = cyc;
    m_run[d]     = 1'b0;
    m_busy[d]    = 1'b0;
    for (int k = 0; k < 4; k++) m_swend[d][k] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] req;
    bit run_prev, low0_prev;
    int tprev;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_ni) begin
        m_reset(d);
      end else begin
        if (cyc < MAXC) fe_log[d][cyc] = (d == 0) ? fe_a : fe_b;
        req       = (d == 0) ? {2'b00, req_a} : req_b;
        run_prev  = m_run[d];
        low0_prev = (cyc - 1) < m_swend[d][0];
        tprev     = cyc - 1 - m_rst_cyc[d];
        for (int k = 0; k < n_of(d); k++) begin
          if (run_prev && req[k]) m_swend[d][k] = cyc + SW;
        end
        if (run_prev) m_run[d] = !req[0];
        else m_run[d] = (tprev >= rel_at(d, n_of(d) - 1)) && !low0_prev && m_fen_s(d);
        m_busy[d] = core_busy;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    logic [7:0] ea, eb;
    ea = '0;
    eb = '0;
    for (int k = 0; k < NA; k++) ea[k] = exp_rst(0, k);
    for (int k = 0; k < NB; k++) eb[k] = exp_rst(1, k);
    check("rst_no_a",   8'(rst_a),  ea);
    check("fetch_en_a", 8'(fen_a),  8'(m_run[0] && m_fen_s(0)));
    check("seq_done_a", 8'(done_a), 8'(m_run[0]));
    check("status_a",   8'(stat_a), 8'(m_busy[0] && ea[0]));
    check("rst_no_b",   8'(rst_b),  eb);
    check("fetch_en_b", 8'(fen_b),  8'(m_run[1] && m_fen_s(1)));
    check("seq_done_b", 8'(done_b), 8'(m_run[1]));
    check("status_b",   8'(stat_b), 8'(m_busy[1] && eb[0]));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_rst(input logic v);
    rst_ni = v;
    #1;
    if (!v) begin
      m_reset(0);
      m_reset(1);
    end
    check_all();
  endtask

  // Boot from reset release: checks the rise times of each reset and of
  // fetch_en_a, counted in edges after rst_ni deasserts.
  task automatic boot_check(input string tag);
    int ra0, ra1, rfa;
    int rb [4];
    ra0 = 0; ra1 = 0; rfa = 0;
    for (int k = 0; k < 4; k++) rb[k] = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (rst_a[0] && ra0 == 0) ra0 = i;
      if (rst_a[1] && ra1 == 0) ra1 = i;
      if (fen_a && rfa == 0) rfa = i;
      for (int k = 0; k < NB; k++) if (rst_b[k] && rb[k] == 0) rb[k] = i;
    end
    check({tag, "_rst_a0_rise"}, 8'(ra0), 8'd3);
    check({tag, "_rst_a1_rise"}, 8'(ra1), 8'd7);
    check({tag, "_fetch_a_rise"}, 8'(rfa), 8'd8);
    for (int k = 0; k < NB; k++) check({tag, "_rst_b_rise"}, 8'(rb[k]), 8'(3 + k));
  endtask

  initial begin
    int cnt, low, rise_i, fen_i, bad;
    bit prev_r0;

    rst_ni    = 1'b0;
    testmode  = 1'b0;
    core_busy = 1'b0;
    fe_a      = 1'b1;
    fe_b      = 1'b0;
    req_a     = '0;
    req_b     = '0;
    m_reset(0);
    m_reset(1);

    repeat (2) tick();

    // Boot with default timing (instance a); 4 domains, gap 1 (instance b)
    set_rst(1'b1);
    boot_check("boot1");
    check("t2_fetch_hold", 8'(fen_b), 8'd0);
    check("t2_wait_done", 8'(done_b), 8'd0);
    fe_b = 1'b1;
    cnt  = 0;
    while (!fen_b && cnt < 10) begin
      tick();
      cnt++;
    end
    check("t2_fetch_latency", 8'(cnt), 8'd2);

    // Soft reset of domain 1: single pulse, then a re-request on cycle 5
    low = 0;
    bad = 0;
    req_a = 2'b10;
    tick();
    req_a = 2'b00;
    if (!rst_a[1]) low++;
    for (int i = 0; i < 14; i++) begin
      core_busy = 1'($urandom_range(0, 1));
      tick();
      if (!rst_a[1]) low++;
      if (!fen_a || !rst_a[0]) bad++;
    end
    check("t3_single_low", 8'(low), 8'd8);
    check("t3_others_kept", 8'(bad), 8'd0);

    low = 0;
    req_a = 2'b10;
    tick();
    req_a = 2'b00;
    if (!rst_a[1]) low++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!rst_a[1]) low++;
    end
    req_a = 2'b10;
    tick();
    req_a = 2'b00;
    if (!rst_a[1]) low++;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!rst_a[1]) low++;
    end
    check("t3_extended_low", 8'(low), 8'd13);

    // Soft reset of domain 0
    core_busy = 1'b1;
    low = 0; bad = 0; rise_i = 0; fen_i = 0;
    req_a = 2'b01;
    tick();
    req_a = 2'b00;
    prev_r0 = rst_a[0];
    if (!rst_a[0]) low++;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (!rst_a[0]) low++;
      if (!rst_a[0] && (fen_a || done_a || stat_a)) bad++;
      if (rst_a[0] && !prev_r0 && rise_i == 0) rise_i = i;
      if (fen_a && fen_i == 0) fen_i = i;
      prev_r0 = rst_a[0];
    end
    check("t4_core_low", 8'(low), 8'd8);
    check("t4_gated_outputs", 8'(bad), 8'd0);
    check("t4_fetch_after_rise", 8'(fen_i - rise_i), 8'd1);
    check("t4_other_domain", 8'(rst_a[1]), 8'd1);

    // core_busy reaches status one cycle later while running
    core_busy = 1'b0;
    tick();
    check("t6_status_low", 8'(stat_a), 8'd0);
    core_busy = 1'b1;
    tick();
    check("t6_status_high", 8'(stat_a), 8'd1);
    core_busy = 1'b0;

    // Reset pulse during RELEASE, then the full sequence again
    set_rst(1'b0);
    repeat (2) tick();
    set_rst(1'b1);
    repeat (4) tick();
    check("t5_mid_release", 8'(rst_a), 8'b01);
    set_rst(1'b0);
    check("t5_async_clear_a", 8'(rst_a), 8'd0);
    check("t5_async_clear_b", 8'(rst_b), 8'd0);
    tick();
    set_rst(1'b1);
    boot_check("boot2");

    // DFT bypass, with soft requests during SYNC/RELEASE
    testmode = 1'b1;
    #1;
    check_all();
    set_rst(1'b0);
    check("t6_bypass_low", 8'(rst_b), 8'h0);
    set_rst(1'b1);
    check("t6_bypass_high", 8'(rst_b), 8'hf);
    for (int i = 0; i < 10; i++) begin
      req_a = 2'($urandom_range(0, 3));
      req_b = 4'($urandom_range(0, 15));
      tick();
    end
    req_a = '0;
    req_b = '0;
    testmode = 1'b0;
    #1;
    check_all();
    repeat (4) tick();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      core_busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) fe_a = ~fe_a;
      if ($urandom_range(0, 15) == 0) fe_b = ~fe_b;
      req_a = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      req_b = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 149) == 0) begin
        set_rst(1'b0);
        tick();
        set_rst(1'b1);
      end
      tick();
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
